// File: rtl/dac_output_sequencer.sv
// Output sequencer in front of the DAC formatter: selects DUC samples, mute or a sawtooth,
// ramps the gain linearly on every enable/disable and counts stream underflows.
module dac_output_sequencer #(
  parameter int DW         = 14,
  parameter int RAMP_SHIFT = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             test_en,
  input  logic [DW-1:0]    test_step,
  input  logic [DW-1:0]    s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [DW-1:0]    dac_data,
  output logic             dac_valid,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] underflow_cnt,
  input  logic             cnt_clr
);

  typedef enum logic [2:0] {
    ST_MUTE      = 3'd0,
    ST_RAMP_UP   = 3'd1,
    ST_RUN       = 3'd2,
    ST_RAMP_DOWN = 3'd3,
    ST_TEST      = 3'd4
  } state_e;

  localparam int GW = RAMP_SHIFT + 1;
  localparam int PW = DW + GW + 1;
  localparam logic [GW-1:0]    G_FULL  = {1'b1, {RAMP_SHIFT{1'b0}}};
  localparam logic [GW-1:0]    G_ONE   = GW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [GW-1:0]    gain_q, gain_d;
  logic [DW-1:0]    acc_q, acc_d;
  logic [DW-1:0]    dac_data_q, dac_data_d;
  logic             dac_valid_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             ramping;
  logic             underflow;
  logic             abort;
  logic [GW-1:0]    gain_inc;
  logic [DW-1:0]    sample;
  logic signed [PW-1:0] sample_ext, gain_ext, product;

  assign ramping   = (state_q == ST_RAMP_UP) || (state_q == ST_RUN) || (state_q == ST_RAMP_DOWN);
  assign underflow = ramping && !s_valid;
  assign abort     = !en || test_en;
  assign gain_inc  = gain_q + G_ONE;
  assign sample    = s_valid ? s_data : '0;

  // Signed sample times zero-extended gain; the arithmetic shift gives floor rounding.
  always_comb begin
    sample_ext = {{(PW-DW){sample[DW-1]}}, sample};
    gain_ext   = {{(PW-GW){1'b0}}, gain_q};
    product    = sample_ext * gain_ext;
  end

  always_comb begin
    dac_data_d = '0;
    unique case (state_q)
      ST_MUTE: dac_data_d = '0;
      ST_TEST: dac_data_d = acc_q;
      default: dac_data_d = DW'(product >>> RAMP_SHIFT);
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr)                       cnt_d = '0;
    else if (underflow && !(&cnt_q))   cnt_d = cnt_q + CNT_ONE;
  end

  // NOTE: every next-state variable gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    acc_d   = acc_q;
    unique case (state_q)
      ST_MUTE: begin
        gain_d = '0;
        acc_d  = '0;
        if (test_en) state_d = ST_TEST;
        else if (en) state_d = ST_RAMP_UP;
      end
      ST_RAMP_UP: begin
        if (abort) begin
          // Reverse from the gain reached so far; at zero gain there is nothing to ramp down.
          state_d = (gain_q == '0) ? ST_MUTE : ST_RAMP_DOWN;
        end else begin
          gain_d = gain_inc;
          if (gain_inc == G_FULL) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        gain_d = G_FULL;
        if (abort) state_d = ST_RAMP_DOWN;
      end
      ST_RAMP_DOWN: begin
        gain_d = gain_q - G_ONE;
        if (gain_q <= G_ONE) begin
          gain_d  = '0;
          state_d = ST_MUTE;
        end
      end
      ST_TEST: begin
        acc_d = acc_q + test_step;
        if (!test_en) begin
          acc_d   = '0;
          state_d = ST_MUTE;
        end
      end
      default: begin
        gain_d  = '0;
        acc_d   = '0;
        state_d = ST_MUTE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_MUTE;
      gain_q      <= '0;
      acc_q       <= '0;
      dac_data_q  <= '0;
      dac_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      gain_q      <= gain_d;
      acc_q       <= acc_d;
      dac_data_q  <= dac_data_d;
      dac_valid_q <= 1'b1;
      cnt_q       <= cnt_d;
    end
  end

  // Ready is low only while reset is held; otherwise every sample is taken.
  assign s_ready       = ~rst;
  assign dac_data      = dac_data_q;
  assign dac_valid     = dac_valid_q;
  assign state         = state_q;
  assign underflow_cnt = cnt_q;

endmodule

// File: tb/tb_dac_output_sequencer.sv
// Self-checking bench for dac_output_sequencer: directed vectors and corner sequences plus
// randomized stimulus compared every cycle against an arithmetic reference model.
module tb_dac_output_sequencer;

  localparam int DW     = 14;
  localparam int RS     = 8;
  localparam int CNT_W  = 16;
  localparam int FULL   = 1 << RS;
  localparam int CMAX   = (1 << CNT_W) - 1;
  localparam int CMAX_S = 15;
  localparam int MASK   = (1 << DW) - 1;

  logic                    clk;
  logic                    rst;
  logic                    en;
  logic                    test_en;
  logic [DW-1:0]           test_step;
  logic signed [DW-1:0]    s_data;
  logic                    s_valid;
  logic                    cnt_clr;
  logic                    s_ready;
  logic [DW-1:0]           dac_data;
  logic                    dac_valid;
  logic [2:0]              state;
  logic [CNT_W-1:0]        underflow_cnt;
  logic                    s_ready_s;
  logic [DW-1:0]           dac_data_s;
  logic                    dac_valid_s;
  logic [2:0]              state_s;
  logic [3:0]              cnt_s;

  dac_output_sequencer #(.DW(DW), .RAMP_SHIFT(RS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .test_en(test_en), .test_step(test_step),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .dac_data(dac_data),
    .dac_valid(dac_valid), .state(state), .underflow_cnt(underflow_cnt), .cnt_clr(cnt_clr)
  );

  // Narrow counter copy, so saturation is reachable in a few cycles.
  dac_output_sequencer #(.DW(DW), .RAMP_SHIFT(RS), .CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .en(en), .test_en(test_en), .test_step(test_step),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_s), .dac_data(dac_data_s),
    .dac_valid(dac_valid_s), .state(state_s), .underflow_cnt(cnt_s), .cnt_clr(cnt_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: mode number as listed for the state port, gain, sawtooth, counts.
  int m_st, m_g, m_acc, m_cnt, m_cnt_s, m_dac, m_valid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic int floor_div(input int num, input int den);
    if (num >= 0) return num / den;
    return -((-num + den - 1) / den);
  endfunction

  task automatic model_advance();
    int  smp;
    bit  uf;
    if (rst) begin
      m_st = 0; m_g = 0; m_acc = 0; m_cnt = 0; m_cnt_s = 0; m_dac = 0; m_valid = 0;
      return;
    end
    m_valid = 1;
    smp = s_valid ? int'(s_data) : 0;
    uf  = !s_valid && (m_st >= 1) && (m_st <= 3);
    if (m_st == 0)      m_dac = 0;
    else if (m_st == 4) m_dac = m_acc;
    else                m_dac = floor_div(smp * m_g, FULL);
    if (cnt_clr) begin
      m_cnt = 0; m_cnt_s = 0;
    end else if (uf) begin
      if (m_cnt < CMAX)     m_cnt++;
      if (m_cnt_s < CMAX_S) m_cnt_s++;
    end
    case (m_st)
      0: begin
        m_g = 0; m_acc = 0;
        if (test_en) m_st = 4;
        else if (en) m_st = 1;
      end
      1: begin
        if (!en || test_en) m_st = (m_g == 0) ? 0 : 3;
        else begin
          m_g++;
          if (m_g == FULL) m_st = 2;
        end
      end
      2: if (!en || test_en) m_st = 3;
      3: begin
        m_g--;
        if (m_g == 0) m_st = 0;
      end
      default: begin
        if (!test_en) begin m_st = 0; m_acc = 0; end
        else m_acc = (m_acc + int'(test_step)) % (1 << DW);
      end
    endcase
  endtask

  task automatic tick();
    model_advance();
    @(posedge clk);
    #1;
    check("m_state", 32'(state), 32'(m_st));
    check("m_dac", 32'(dac_data), 32'(m_dac & MASK));
    check("m_valid", 32'(dac_valid), 32'(m_valid));
    check("m_ready", 32'(s_ready), 32'(!rst));
    check("m_cnt", 32'(underflow_cnt), 32'(m_cnt));
    check("m_cnt_small", 32'(cnt_s), 32'(m_cnt_s));
  endtask

  task automatic wait_state(input string name, input int target, input int budget);
    int n = 0;
    while (int'(state) != target && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(state), 32'(target));
  endtask

  typedef struct {
    int            g;
    logic [DW-1:0] s;
    logic [DW-1:0] exp;
  } vec_t;

  localparam int NV = 11;
  vec_t vec[NV];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int n;
    bit hit;

    // Gain-ramp vectors: {gain during the cycle, sample, floor(sample*g/256)}.
    vec[0]  = '{0,   14'(8191),  14'(0)};
    vec[1]  = '{1,   14'(8191),  14'(31)};
    vec[2]  = '{2,   14'(8191),  14'(63)};
    vec[3]  = '{64,  14'(-1),    14'(-1)};
    vec[4]  = '{100, 14'(5000),  14'(1953)};
    vec[5]  = '{127, 14'(-8192), 14'(-4064)};
    vec[6]  = '{128, 14'(-8192), 14'(-4096)};
    vec[7]  = '{129, 14'(1),     14'(0)};
    vec[8]  = '{130, 14'(-1),    14'(-1)};
    vec[9]  = '{200, 14'(-3),    14'(-3)};
    vec[10] = '{255, 14'(8191),  14'(8159)};

    rst = 1'b1; en = 1'b0; test_en = 1'b0; test_step = '0;
    s_data = '0; s_valid = 1'b1; cnt_clr = 1'b0;
    repeat (3) tick();
    check("rst_state", 32'(state), 0);
    check("rst_dac", 32'(dac_data), 0);
    check("rst_valid", 32'(dac_valid), 0);
    check("rst_ready", 32'(s_ready), 0);
    check("rst_cnt", 32'(underflow_cnt), 0);
    rst = 1'b0;
    #1;
    check("first_valid", 32'(dac_valid), 0);
    check("first_ready", 32'(s_ready), 1);

    // Ramp up with table-driven samples at selected gains.
    en = 1'b1; s_data = 14'sd8191;
    tick();
    check("ru_entry", 32'(state), 1);
    idx = 0;
    for (int k = 0; k < FULL; k++) begin
      hit = (idx < NV) && (vec[idx].g == k);
      s_data = hit ? vec[idx].s : 14'sd8191;
      tick();
      if (hit) begin
        check($sformatf("ramp_g%0d", k), 32'(dac_data), 32'(vec[idx].exp));
        idx++;
      end
    end
    check("run_entry", 32'(state), 2);
    s_data = 14'sd8191;
    tick();
    check("run_pass", 32'(dac_data), 8191);

    // Ramp down; en comes back at g=100 and must be ignored until MUTE.
    en = 1'b0;
    tick();
    check("rd_entry", 32'(state), 3);
    n = 0;
    while (state == 3'd3 && n < 400) begin
      if (n == FULL - 100) en = 1'b1;
      tick();
      n++;
    end
    check("rd_len", 32'(n), 32'(FULL));
    check("rd_mute", 32'(state), 0);
    tick();
    check("reramp", 32'(state), 1);
    repeat (10) tick();
    en = 1'b0;
    wait_state("short_ramp_mute", 0, 50);

    // Sawtooth from MUTE.
    test_en = 1'b1; test_step = 14'h0400;
    tick();
    check("test_entry", 32'(state), 4);
    for (int i = 0; i < 18; i++) begin
      tick();
      check($sformatf("saw%0d", i), 32'(dac_data), 32'((i * 1024) % 16384));
    end
    test_en = 1'b0;
    tick();
    check("test_exit", 32'(state), 0);

    // test_en while running: ramp down first, then TEST.
    en = 1'b1;
    wait_state("run_again", 2, 300);
    test_en = 1'b1;
    tick();
    check("test_rd", 32'(state), 3);
    wait_state("test_rd_mute", 0, 300);
    tick();
    check("test_after_rd", 32'(state), 4);
    tick();
    check("test_first", 32'(dac_data), 0);
    test_en = 1'b0;
    tick();
    wait_state("run_uf", 2, 300);

    // Underflow counting, saturation and clear priority.
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    s_valid = 1'b0;
    repeat (5) begin
      tick();
      check("uf_dac", 32'(dac_data), 0);
    end
    s_valid = 1'b1;
    tick();
    check("uf_cnt5", 32'(underflow_cnt), 5);
    check("uf_dac_back", 32'(dac_data), 8191);
    s_valid = 1'b0;
    repeat (20) tick();
    check("sat_small", 32'(cnt_s), 15);
    check("cnt25", 32'(underflow_cnt), 25);
    cnt_clr = 1'b1;
    tick();
    check("clr_wins", 32'(underflow_cnt), 0);
    check("clr_wins_small", 32'(cnt_s), 0);
    cnt_clr = 1'b0; s_valid = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) == 0)  en = ~en;
      if ($urandom_range(0, 299) == 0) test_en = ~test_en;
      s_valid   = ($urandom_range(0, 9) != 0);
      s_data    = 14'($urandom);
      test_step = 14'($urandom);
      cnt_clr   = ($urandom_range(0, 199) == 0);
      rst       = ($urandom_range(0, 999) == 0);
      tick();
    end

    // Reset in the middle of a ramp-up at g=50.
    rst = 1'b0; en = 1'b0; test_en = 1'b0; cnt_clr = 1'b0; s_valid = 1'b1;
    wait_state("pre_rst_mute", 0, 600);
    en = 1'b1;
    tick();
    s_valid = 1'b0;
    repeat (3) tick();
    s_valid = 1'b1;
    repeat (47) tick();
    check("pre_rst_state", 32'(state), 1);
    rst = 1'b1;
    tick();
    check("mid_rst_state", 32'(state), 0);
    check("mid_rst_dac", 32'(dac_data), 0);
    check("mid_rst_valid", 32'(dac_valid), 0);
    check("mid_rst_cnt", 32'(underflow_cnt), 0);
    rst = 1'b0; en = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dac_output_sequencer.md
# dac_output_sequencer

Controls the output stream that feeds the DAC formatter stage. Selects between summed DUC samples, mute (midscale zero) and a built-in sawtooth test pattern. Applies a linear gain ramp on every enable/disable so the analog output never steps abruptly. Also counts stream underflows. Sits between the channel combiner and the DAC two's-complement-to-offset-binary output register, at the DAC sample clock.

## Interface
Parameters:
- DW, 14, sample width (two's complement) in and out
- RAMP_SHIFT, 8, ramp length = 2^RAMP_SHIFT cycles; gain register width RAMP_SHIFT+1
- CNT_W, 16, underflow counter width

Ports:
- clk  in  1  DAC sample clock; the only clock
- rst  in  1  synchronous, active-high reset
- en  in  1  level; request normal output
- test_en  in  1  level; request test pattern (priority over en)
- test_step  in  DW  sawtooth increment per cycle (unsigned, wraps modulo 2^DW)
- s_data  in  DW  signed input sample
- s_valid  in  1  s_data valid this cycle
- s_ready  out  1  always 1 after reset; every presented sample is consumed
- dac_data  out  DW  signed sample to DAC formatter
- dac_valid  out  1  0 in the first cycle after reset, 1 thereafter
- state  out  3  MUTE=0, RAMP_UP=1, RUN=2, RAMP_DOWN=3, TEST=4
- underflow_cnt  out  CNT_W  saturating count of underflows
- cnt_clr  in  1  synchronous clear of underflow_cnt

## Operation
- Reset values:
  - state=MUTE, gain g=0, sawtooth acc=0
  - dac_data=0, dac_valid=0, s_ready=0 during reset
  - underflow_cnt=0
- FULL = 2^RAMP_SHIFT. Gain is applied as y = (s_data * g) >>> RAMP_SHIFT: signed × unsigned product, arithmetic shift, floor rounding. g=FULL passes samples unchanged; g=0 yields 0.
- MUTE:
  - dac_data=0; samples are consumed and discarded.
  - test_en → TEST; else en → RAMP_UP.
- RAMP_UP:
  - g<=g+1 each cycle.
  - When g+1==FULL → RUN.
  - If en=0 or test_en=1 → RAMP_DOWN, starting from the current g (no gain jump).
- RUN:
  - g=FULL.
  - en=0 or test_en=1 → RAMP_DOWN.
- RAMP_DOWN:
  - g<=g-1 each cycle.
  - When g-1==0 → MUTE.
  - Always runs to completion; en reasserting mid-ramp is ignored until MUTE is reached, then re-evaluated.
- TEST:
  - Entered only from MUTE, with acc=0.
  - dac_data=acc; acc<=acc+test_step each cycle, wrapping.
  - test_en=0 → MUTE, and acc is cleared.
  - No ramp is applied in TEST.
- Underflow:
  - Occurs when s_valid=0 in RAMP_UP, RUN or RAMP_DOWN.
  - The sample is treated as 0 and underflow_cnt increments, saturating at all-ones.
  - s_valid=0 in MUTE or TEST is not an underflow.
- cnt_clr with a simultaneous underflow: the clear wins and the count becomes 0.

## Timing
- Single register stage. A sample accepted in cycle n appears on dac_data in cycle n+1, scaled by the g value held during cycle n.
- Gain trajectory:
  - MUTE→RAMP_UP transition in cycle t: g=0 during t+1; g=k during t+1+k.
  - RUN is entered with g=FULL, 2^RAMP_SHIFT cycles after RAMP_UP entry.
  - RAMP_DOWN from RUN reaches MUTE after FULL cycles.
- TEST: the first dac_data is 0, one cycle after TEST entry; it then advances by test_step per cycle.
- state changes take effect on the clock edge after the triggering input level is sampled.
- Reset asserted mid-ramp or mid-TEST: the next cycle shows all reset values; no ramp-down is performed.

## Test plan
- Reset, then en=1 with s_data=8191 constant, RAMP_SHIFT=8 → dac_data rises 0,31,63,… (floor(8191·k/256)); state=RUN after 256 cycles; dac_data=8191 thereafter.
- In RAMP_UP at g=128: s_data=-8192 → -4096; s_data=1 → 0; s_data=-1 → -1 (floor rounding check).
- In RUN, drop en → 256-cycle ramp to 0 then MUTE. Reassert en at g=100 during RAMP_DOWN → continues to MUTE, then RAMP_UP starts.
- In MUTE, set test_en=1, test_step=0x0400 → dac_data 0,0x0400,0x0800,…, wraps after 16 steps. test_en in RUN → ramp down first, then TEST.
- In RUN, hold s_valid=0 for 5 cycles → underflow_cnt=5 and dac_data=0 on those outputs. Force the count to 0xFFFF and underflow again → stays 0xFFFF. cnt_clr together with an underflow → 0.
- Assert rst mid-RAMP_UP (g=50) → next cycle state=0, dac_data=0, dac_valid=0, underflow_cnt=0.
